// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - XLEN datapath width (32 only)
//   - ALU_Control codes (ALU_ADD..ALU_SLTU)
//   - RV32I major opcodes and the funct7 values the issue stage accepts
//   - immediate-type enum plus the immediate generator
//   - issue_entry_t: one decoded entry as held in the skid buffer
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U,
    IMM_SHAMT
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      alu_control;
    logic [4:0]      rd;
    logic            illegal;
  } issue_entry_t;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr,
                                              input imm_type_e   sel);
    logic [XLEN-1:0] imm;
    case (sel)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundles around the ALU issue stage.
//   alu_issue_in_if : register-read side -> issue stage
//     in_valid, instr, pc, rs1_data, rs2_data (master drives), in_ready (slave drives)
//   alu_issue_out_if: issue stage -> ALU/execute
//     out_valid, A, B, ALU_Control, rd, illegal (master drives), out_ready (slave drives)
interface alu_issue_in_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data,
    output in_ready
  );
endinterface

interface alu_issue_out_if;
  import alu_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [3:0]      ALU_Control;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    output out_valid, A, B, ALU_Control, rd, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, A, B, ALU_Control, rd, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operands and op code.
//   instr, pc, rs1_data, rs2_data -> entry {a, b, alu_control, rd, illegal}
// Any unsupported opcode/funct combination yields an all-zero entry with
// only illegal set, so the consumer sees a clean trap marker.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_entry_t    entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Source register indices are resolved upstream; only their data arrives here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [XLEN-1:0] a_val;
  logic [XLEN-1:0] b_val;
  logic [3:0]      ctl;
  logic            bad;
  imm_type_e       imm_sel;

  always_comb begin
    a_val   = '0;
    b_val   = '0;
    ctl     = ALU_ADD;
    bad     = 1'b0;
    imm_sel = IMM_NONE;
    entry   = '0;

    case (opcode)
      OPC_OP: begin
        a_val = rs1_data;
        b_val = rs2_data;
        ctl   = f3_to_alu(funct3, instr[30]);
        bad   = !((funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        a_val = rs1_data;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          imm_sel = IMM_SHAMT;
          ctl     = f3_to_alu(funct3, instr[30]);
          bad     = !((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && (funct3 == 3'b101)));
        end else begin
          // No SUBI: bit 30 is just immediate here.
          imm_sel = IMM_I;
          ctl     = f3_to_alu(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        a_val   = rs1_data;
        imm_sel = IMM_I;
      end
      OPC_STORE: begin
        a_val   = rs1_data;
        imm_sel = IMM_S;
      end
      OPC_LUI: begin
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        a_val   = pc;
        imm_sel = IMM_U;
      end
      OPC_BRANCH: begin
        a_val = rs1_data;
        b_val = rs2_data;
        case (funct3[2:1])
          2'b00:   ctl = ALU_SUB;
          2'b10:   ctl = ALU_SLT;
          2'b11:   ctl = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    // Every supported opcode already ends in 11; kept explicit for clarity.
    if (instr[1:0] != 2'b11) bad = 1'b1;

    if (imm_sel != IMM_NONE) b_val = imm_gen(instr, imm_sel);

    if (bad) begin
      entry.illegal = 1'b1;
    end else begin
      entry.a           = a_val;
      entry.b           = b_val;
      entry.alu_control = ctl;
      entry.rd          = instr[11:7];
      entry.illegal     = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and registers it toward the ALU
// through a 2-entry skid buffer (main + skid).
//   clk, rst_n  clock, async active-low reset
//   flush       synchronous discard of both entries (beats all transfers)
//   up          alu_issue_in_if.slave  (in_valid/in_ready + instr, pc, rs1/rs2 data)
//   dn          alu_issue_out_if.master (out_valid/out_ready + A, B, ALU_Control, rd, illegal)
// in_ready is a flop, so out_ready never reaches the upstream combinationally.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, out_valid=0, in_ready=1
//   ST_ONE   | main holds an entry, skid empty, in_ready=1
//   ST_TWO   | main and skid hold entries, in_ready=0
module alu_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  alu_issue_in_if.slave   up,
  alu_issue_out_if.master dn
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  skid_state_e  state_q;
  issue_entry_t dec_entry;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         accept;
  logic         drain;

  alu_op_decode u_decode (
    .instr    (up.instr),
    .pc       (up.pc),
    .rs1_data (up.rs1_data),
    .rs2_data (up.rs2_data),
    .entry    (dec_entry)
  );

  assign accept = up.in_valid & in_ready_q;
  assign drain  = out_valid_q & dn.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= dec_entry;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, drain})
            // Reload main in the same cycle it drains: no bubble.
            2'b11: main_q <= dec_entry;
            2'b10: begin
              skid_q     <= dec_entry;
              in_ready_q <= 1'b0;
              state_q    <= ST_TWO;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (drain) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign up.in_ready    = in_ready_q;
  assign dn.out_valid   = out_valid_q;
  assign dn.A           = main_q.a;
  assign dn.B           = main_q.b;
  assign dn.ALU_Control = main_q.alu_control;
  assign dn.rd          = main_q.rd;
  assign dn.illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode cases, back-pressure,
// streaming, flush, async reset and a randomized handshake run, all checked
// against a queue-based reference model.
module tb_alu_issue;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_issue_in_if  up_if ();
  alu_issue_out_if dn_if ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   dut_acc = 0;
  int   dut_del = 0;

  // ALU code by funct3 for the non-alternate encodings.
  logic [3:0] op_lut [0:7] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t               e;
    logic signed [31:0] s;
    logic [31:0]        immi;
    logic [2:0]         f3;
    logic [6:0]         f7;
    s    = ins;
    immi = s >>> 20;
    f3   = ins[14:12];
    f7   = ins[31:25];
    e.a = 0; e.b = 0; e.ctl = 0; e.rd = ins[11:7]; e.ill = 0;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.ctl = op_lut[f3];
        if (f7 == 7'h20) begin
          if (f3 == 0) e.ctl = 1;
          else if (f3 == 5) e.ctl = 7;
          else e.ill = 1;
        end else if (f7 != 0) e.ill = 1;
      end
      7'h13: begin
        e.a = r1; e.b = immi; e.ctl = op_lut[f3];
        if (f3 == 1) begin
          e.b = {27'b0, ins[24:20]};
          if (f7 != 0) e.ill = 1;
        end
        if (f3 == 5) begin
          e.b = {27'b0, ins[24:20]};
          if (f7 == 7'h20) e.ctl = 7;
          else if (f7 != 0) e.ill = 1;
        end
      end
      7'h03: begin e.a = r1; e.b = immi; end
      7'h23: begin e.a = r1; e.b = (immi & 32'hFFFF_FFE0) | {27'b0, ins[11:7]}; end
      7'h37: e.b = ins & 32'hFFFF_F000;
      7'h17: begin e.a = p; e.b = ins & 32'hFFFF_F000; end
      7'h63: begin
        e.a = r1; e.b = r2;
        case (f3 >> 1)
          0: e.ctl = 1;
          2: e.ctl = 8;
          3: e.ctl = 9;
          default: e.ill = 1;
        endcase
      end
      default: e.ill = 1;
    endcase
    if (ins[1:0] != 2'b11) e.ill = 1;
    if (e.ill) begin e.a = 0; e.b = 0; e.ctl = 0; e.rd = 0; end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    case ($urandom_range(0, 8))
      0, 7: ins[6:0] = 7'h33;
      1:    ins[6:0] = 7'h13;
      2:    ins[6:0] = 7'h03;
      3:    ins[6:0] = 7'h23;
      4:    ins[6:0] = 7'h37;
      5:    ins[6:0] = 7'h17;
      6:    ins[6:0] = 7'h63;
      default: ;
    endcase
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      k = $urandom_range(0, 3);
      if (k < 2) ins[31:25] = 7'h00;
      else if (k == 2) ins[31:25] = 7'h20;
    end
    return ins;
  endfunction

  // Called just after a rising edge: apply inputs, check outputs at the
  // falling edge, then advance the model across the next rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    logic xin, xout;
    up_if.in_valid    = v;
    up_if.instr       = ins;
    up_if.pc          = p;
    up_if.rs1_data    = r1;
    up_if.rs2_data    = r2;
    dn_if.out_ready   = ordy;
    flush             = fl;
    @(negedge clk);
    check_val("out_valid", {31'b0, dn_if.out_valid}, {31'b0, q.size() > 0});
    check_val("in_ready",  {31'b0, up_if.in_ready},  {31'b0, q.size() < 2});
    if (q.size() > 0 && dn_if.out_valid) begin
      check_val("A",           dn_if.A,                   q[0].a);
      check_val("B",           dn_if.B,                   q[0].b);
      check_val("ALU_Control", {28'b0, dn_if.ALU_Control}, {28'b0, q[0].ctl});
      check_val("rd",          {27'b0, dn_if.rd},          {27'b0, q[0].rd});
      check_val("illegal",     {31'b0, dn_if.illegal},     {31'b0, q[0].ill});
    end
    xin  = v && (q.size() < 2);
    xout = ordy && (q.size() > 0);
    if (v && up_if.in_ready)     dut_acc++;
    if (ordy && dn_if.out_valid) dut_del++;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (xout) void'(q.pop_front());
      if (xin)  q.push_back(ref_dec(ins, p, r1, r2));
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [3:0] ectl,
                          input logic [31:0] ea, input logic [31:0] eb,
                          input logic [4:0] erd, input logic eill);
    cycle(1'b1, ins, 32'h0000_1000, r1, r2, 1'b1, 1'b0);
    check_val({nm, "_valid"}, {31'b0, dn_if.out_valid},   32'd1);
    check_val({nm, "_ctl"},   {28'b0, dn_if.ALU_Control}, {28'b0, ectl});
    check_val({nm, "_A"},     dn_if.A,                    ea);
    check_val({nm, "_B"},     dn_if.B,                    eb);
    check_val({nm, "_rd"},    {27'b0, dn_if.rd},          {27'b0, erd});
    check_val({nm, "_ill"},   {31'b0, dn_if.illegal},     {31'b0, eill});
    idle(1'b1);
  endtask

  task automatic reset_outputs_zero(input string nm);
    check_val({nm, "_out_valid"}, {31'b0, dn_if.out_valid},   32'd0);
    check_val({nm, "_in_ready"},  {31'b0, up_if.in_ready},    32'd1);
    check_val({nm, "_A"},         dn_if.A,                    32'd0);
    check_val({nm, "_B"},         dn_if.B,                    32'd0);
    check_val({nm, "_ctl"},       {28'b0, dn_if.ALU_Control}, 32'd0);
    check_val({nm, "_rd"},        {27'b0, dn_if.rd},          32'd0);
    check_val({nm, "_ill"},       {31'b0, dn_if.illegal},     32'd0);
  endtask

  initial begin
    int          a0, d0;
    logic [31:0] hold_ins, hold_pc, hold_r1, hold_r2;

    up_if.in_valid  = 1'b0;
    up_if.instr     = '0;
    up_if.pc        = '0;
    up_if.rs1_data  = '0;
    up_if.rs2_data  = '0;
    dn_if.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1 reset_outputs_zero("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add",   32'h0020_81B3, 32'd5,  32'd7, 4'd0, 32'd5,  32'd7,          5'd3, 1'b0);
    directed("srai",  32'h4041_5093, 32'h80, 32'd0, 4'd7, 32'h80, 32'd4,          5'd1, 1'b0);
    directed("addi",  32'hFFF0_0093, 32'd0,  32'd0, 4'd0, 32'd0,  32'hFFFF_FFFF,  5'd1, 1'b0);
    directed("lui",   32'h1234_52B7, 32'd9,  32'd9, 4'd0, 32'd0,  32'h1234_5000,  5'd5, 1'b0);
    directed("bad7f", 32'h0000_007F, 32'd9,  32'd9, 4'd0, 32'd0,  32'd0,          5'd0, 1'b1);
    directed("badxr", 32'h4020_C1B3, 32'd9,  32'd9, 4'd0, 32'd0,  32'd0,          5'd0, 1'b1);

    // Back-pressure: four offers against a stalled consumer.
    a0 = dut_acc;
    for (int i = 0; i < 4; i++) cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b0);
    check_val("bp_accepted", dut_acc - a0, 32'd2);
    d0 = dut_del;
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_val("bp_delivered", dut_del - d0, 32'd2);

    // Full-rate streaming.
    d0 = dut_del;
    for (int i = 0; i < 16; i++) cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b1, 1'b0);
    check_val("stream_delivered", dut_del - d0, 32'd15);
    idle(1'b1);

    // Flush with both entries full; the flush-cycle input is dropped.
    cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b1);
    check_val("flush_out_valid", {31'b0, dn_if.out_valid}, 32'd0);
    check_val("flush_in_ready",  {31'b0, up_if.in_ready},  32'd1);
    idle(1'b1);

    // Async reset pulse mid-stream, released between edges with an input waiting.
    for (int i = 0; i < 3; i++) cycle(1'b1, gen_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b0);
    hold_ins = 32'h0020_81B3; hold_pc = 32'h40; hold_r1 = 32'd11; hold_r2 = 32'd22;
    up_if.in_valid = 1'b1; up_if.instr = hold_ins; up_if.pc = hold_pc;
    up_if.rs1_data = hold_r1; up_if.rs2_data = hold_r2; dn_if.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero("arst");
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(ref_dec(hold_ins, hold_pc, hold_r1, hold_r2));
    check_val("arst_first_accept", {31'b0, dn_if.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized handshake run.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that feeds the ALU. Decodes an RV32I instruction plus its register-file operands into the ALU's operand pair (A, B) and 4-bit ALU_Control code. Registers the result toward the ALU/execute side through a valid/ready handshake with a 2-entry skid buffer, so back-pressure never combinationally reaches the fetch/decode side. Sits between register-file read and the ALU in the pipelined core.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous: discard all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept; registered (equals "skid entry empty").
- instr  input  32  instruction word.
- pc  input  XLEN  instruction address.
- rs1_data, rs2_data  input  XLEN  register-file read values.
- out_valid  output  1  A/B/ALU_Control/rd/illegal valid.
- out_ready  input  1  downstream accepts.
- A, B  output  XLEN  ALU operands.
- ALU_Control  output  4  ALU op code.
- rd  output  5  destination register (instr[11:7]).
- illegal  output  1  opcode/funct combination not supported.

## Operation
- ALU_Control codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- OP (0110011): A=rs1, B=rs2. funct3 000 → instr[30]?SUB:ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → instr[30]?SRA:SRL; 110 OR; 111 AND. funct7 other than 0000000/0100000, or 0100000 with funct3 ∉ {000,101} → illegal.
- OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20]; same mapping except 000 is always ADD. For 001/101, B=zero-extended instr[24:20]; instr[31:25] must be 0000000 (or 0100000 for SRAI), else illegal.
- LOAD (0000011) / STORE (0100011): ADD, A=rs1, B=sign-extended I-imm / S-imm ({instr[31:25],instr[11:7]}).
- LUI (0110111): ADD, A=0, B={instr[31:12],12'b0}. AUIPC (0010111): ADD, A=pc, B=U-imm.
- BRANCH (1100011): A=rs1, B=rs2; funct3 00x SUB, 10x SLT, 11x SLTU; 01x illegal.
- Any other opcode, or instr[1:0]≠11: illegal=1, ALU_Control=0, A=B=0, rd=0.
- Illegal entries still flow through the handshake; the consumer raises the trap.
- Skid buffer: main register drives outputs; skid register captures an accepted input when main is full and not draining. Entries leave in acceptance order.

## Timing
- Reset (async, rst_n low): out_valid=0, in_ready=1, A=B=0, ALU_Control=0, rd=0, illegal=0, both entries empty. Data registers also clear.
- Latency: an accepted input appears on outputs the next cycle (1 cycle). Throughput: 1/cycle while out_ready=1.
- Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready. Outputs hold stable while out_valid&!out_ready.
- in_ready drops the cycle after the skid entry fills. It rises the cycle after the skid entry drains into main.
- Simultaneous in/out transfer with skid empty: main reloads with the new entry, no bubble.
- flush: next cycle both entries are empty, out_valid=0, in_ready=1. An input presented in the flush cycle is discarded. flush has priority over all transfers.
- rst_n asserted mid-transfer: state clears immediately. First accept is possible on the first rising edge after deassertion.

## Structure
- Package alu_pkg: ALU_Control localparams (ALU_ADD..ALU_SLTU), RV32I opcode constants, immediate-type enum.
- Sub-module alu_op_decode: purely combinational instr/pc/rs1/rs2 → {A, B, ALU_Control, rd, illegal}. alu_issue holds only the handshake and skid registers.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7: next cycle out_valid=1, ALU_Control=0, A=5, B=7, rd=3, illegal=0.
- srai x1,x2,4 (0x40415093) → ALU_Control=7, B=4. addi x1,x0,-1 (0xFFF00093) → ADD, B=0xFFFFFFFF. lui x5,0x12345 (0x123452B7) → A=0, B=0x12345000.
- Illegal: 0x0000007F and funct7=0100000 with funct3=100 on OP → illegal=1, ALU_Control=0, A=B=0. The entry is still delivered.
- Back-pressure: stream 4 instructions with out_ready=0 → 2 accepted, in_ready=0 from the 3rd cycle. Release out_ready → all accepted instructions delivered in order, none duplicated.
- Streaming with out_ready=1 for 16 cycles → one output per cycle, in_ready constantly 1.
- flush with both entries full → next cycle out_valid=0, in_ready=1. Async rst_n pulse mid-stream → outputs zero immediately.
